rd_ctrl_gray: RTL and testbench

Parametrised read-side controller for the dual-clock FIFO. It supersedes the plain binary read controller with the following features:
- Gray-coded read pointer for crossing into the write domain.
- Built-in configurable synchroniser for the incoming write pointer.
- Registered fill level, almost-empty threshold and underflow detection.
- Separate RAM address and read-enable outputs.

It sits in the read clock domain between the FIFO storage RAM and the consumer.

---
 rtl/cdc_fifo_pkg.sv | 35 +++
 rtl/sync_bus_ff.sv | 38 +++
 rtl/rd_ctrl_gray.sv | 90 +++++++++
 tb/tb_rd_ctrl_gray.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers (read and write side).
package cdc_fifo_pkg;

    // Widest pointer the helpers handle; callers cast their pointer in and the result back.
    localparam int LP_MAX_W = 32;

    typedef logic [LP_MAX_W-1:0] wide_t;

    // Binary to reflected Gray. Zero-extension keeps this exact for any narrower width.
    function automatic wide_t bin2gray(input wide_t i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Gray to binary by prefix XOR from the MSB down. Leading zeros of a
    // zero-extended Gray value leave the low bits exact.
    function automatic wide_t gray2bin(input wide_t i_gray);
        wide_t w_bin;
        w_bin[LP_MAX_W-1] = i_gray[LP_MAX_W-1];
        for (int i = LP_MAX_W - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ i_gray[i];
        end
        return w_bin;
    endfunction

    // Synchroniser depth: 0 means same-clock bypass, otherwise 2..4 flops.
    function automatic bit sync_stages_legal(input int i_stages);
        return (i_stages == 0) || ((i_stages >= 2) && (i_stages <= 4));
    endfunction

    // Fill-level thresholds must lie within 0..depth.
    function automatic bit thresh_legal(input int i_thresh, input int i_addr_w);
        return (i_thresh >= 0) && (i_thresh <= (1 << i_addr_w));
    endfunction

endpackage

// File: rtl/sync_bus_ff.sv
// Multi-flop synchroniser for a Gray-coded bus; P_STAGES=0 wires the bus straight through.
module sync_bus_ff #(
    parameter int P_WIDTH  = 1,
    parameter int P_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] i_d,
    output logic [P_WIDTH-1:0] o_q
);

    generate
        if (P_STAGES == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_chain
            logic [P_WIDTH-1:0] r_stage [P_STAGES];

            // Shift the incoming bus through the flop chain; all stages clear on reset.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int s = 0; s < P_STAGES; s++) begin
                        r_stage[s] <= '0;
                    end
                end else begin
                    // NOTE: non-blocking assignments make every stage sample its
                    // predecessor's old value, so the chain shifts one stage per clock.
                    r_stage[0] <= i_d;
                    for (int s = 1; s < P_STAGES; s++) begin
                        r_stage[s] <= r_stage[s-1];
                    end
                end
            end

            assign o_q = r_stage[P_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rd_ctrl_gray.sv
// Read-side controller of the dual-clock FIFO: Gray read pointer, synchronised write
// pointer, registered empty / almost-empty / level / underflow flags.
module rd_ctrl_gray #(
    parameter int P_ADDR_W      = 4,
    parameter int P_SYNC_STAGES = 2,
    parameter int P_AE_THRESH   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_inc,
    input  logic [P_ADDR_W:0]   i_wr_ptr_gray,
    output logic [P_ADDR_W:0]   o_rd_ptr_gray,
    output logic [P_ADDR_W-1:0] o_rd_addr,
    output logic                o_rd_en,
    output logic                o_empty,
    output logic                o_almost_empty,
    output logic [P_ADDR_W:0]   o_level,
    output logic                o_underflow
);

    import cdc_fifo_pkg::*;

    localparam int LP_PTR_W = P_ADDR_W + 1;

    typedef logic [LP_PTR_W-1:0] ptr_t;

    localparam ptr_t LP_AE_THRESH = ptr_t'(P_AE_THRESH);

    generate
        if (!sync_stages_legal(P_SYNC_STAGES)) begin : g_bad_sync
            $error("rd_ctrl_gray: P_SYNC_STAGES must be 0 or 2..4");
        end
        if (!thresh_legal(P_AE_THRESH, P_ADDR_W)) begin : g_bad_thresh
            $error("rd_ctrl_gray: P_AE_THRESH must be within 0..2**P_ADDR_W");
        end
    endgenerate

    ptr_t r_rd_bin;
    ptr_t w_wr_gray_s;
    ptr_t w_wr_bin_s;
    ptr_t w_rd_bin_nxt;
    ptr_t w_rd_gray_nxt;
    ptr_t w_level_nxt;

    // Only the Gray pointer crosses domains; it changes one bit per write, so any
    // sampling skew resolves to either the old or the new pointer value.
    sync_bus_ff #(
        .P_WIDTH  (LP_PTR_W),
        .P_STAGES (P_SYNC_STAGES)
    ) u_wr_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_wr_ptr_gray),
        .o_q     (w_wr_gray_s)
    );

    assign w_wr_bin_s    = ptr_t'(gray2bin(wide_t'(w_wr_gray_s)));

    // A read is accepted only when the registered empty flag is clear.
    assign o_rd_en       = i_inc & ~o_empty;

    // The pointer MSB is the wrap bit; the addition wraps naturally at 2**LP_PTR_W.
    assign w_rd_bin_nxt  = r_rd_bin + ptr_t'(o_rd_en);
    assign w_rd_gray_nxt = ptr_t'(bin2gray(wide_t'(w_rd_bin_nxt)));

    // Modulo difference stays correct across pointer wrap; a full FIFO reads as depth.
    assign w_level_nxt   = w_wr_bin_s - w_rd_bin_nxt;

    // Register pointers and status flags from the next-state values of this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_bin       <= '0;
            o_rd_ptr_gray  <= '0;
            o_rd_addr      <= '0;
            o_empty        <= 1'b1;
            o_almost_empty <= 1'b1;
            o_level        <= '0;
            o_underflow    <= 1'b0;
        end else begin
            r_rd_bin       <= w_rd_bin_nxt;
            o_rd_ptr_gray  <= w_rd_gray_nxt;
            o_rd_addr      <= w_rd_bin_nxt[P_ADDR_W-1:0];
            o_empty        <= (w_rd_gray_nxt == w_wr_gray_s);
            o_almost_empty <= (w_level_nxt <= LP_AE_THRESH);
            o_level        <= w_level_nxt;
            o_underflow    <= i_inc & o_empty;
        end
    end

endmodule

// File: tb/tb_rd_ctrl_gray.sv
// Self-checking bench for rd_ctrl_gray: a synchronised instance (2 stages) and a
// bypassed instance (0 stages) share stimulus and are compared against a
// count-based model of the read side of the FIFO.
module tb_rd_ctrl_gray;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inc;
    logic [PW-1:0] wr_gray;

    logic [PW-1:0] gray_w  [2];
    logic [AW-1:0] addr_w  [2];
    logic          en_w    [2];
    logic          empty_w [2];
    logic          ae_w    [2];
    logic [PW-1:0] level_w [2];
    logic          uf_w    [2];

    rd_ctrl_gray #(.P_ADDR_W(AW), .P_SYNC_STAGES(2), .P_AE_THRESH(AE)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_inc          (inc),
        .i_wr_ptr_gray  (wr_gray),
        .o_rd_ptr_gray  (gray_w[0]),
        .o_rd_addr      (addr_w[0]),
        .o_rd_en        (en_w[0]),
        .o_empty        (empty_w[0]),
        .o_almost_empty (ae_w[0]),
        .o_level        (level_w[0]),
        .o_underflow    (uf_w[0])
    );

    rd_ctrl_gray #(.P_ADDR_W(AW), .P_SYNC_STAGES(0), .P_AE_THRESH(AE)) dut_bypass (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_inc          (inc),
        .i_wr_ptr_gray  (wr_gray),
        .o_rd_ptr_gray  (gray_w[1]),
        .o_rd_addr      (addr_w[1]),
        .o_rd_en        (en_w[1]),
        .o_empty        (empty_w[1]),
        .o_almost_empty (ae_w[1]),
        .o_level        (level_w[1]),
        .o_underflow    (uf_w[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: unbounded word counts; the read side sees the write count S edges late.
    int            wr_cnt;
    int            hist[$];
    int            m_rd      [2];
    int            m_rd_prev [2];
    int            m_level   [2];
    bit            m_empty   [2];
    bit            m_ae      [2];
    bit            m_uf      [2];
    logic [PW-1:0] prev_gray [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sync_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [PW-1:0] gray_of(input int cnt);
        int b;
        b = cnt % (2 * DEPTH);
        return PW'(b ^ (b >> 1));
    endfunction

    task automatic model_reset();
        wr_cnt  = 0;
        wr_gray = '0;
        inc     = 1'b0;
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_rd[i]      = 0;
            m_rd_prev[i] = 0;
            m_level[i]   = 0;
            m_empty[i]   = 1'b1;
            m_ae[i]      = 1'b1;
            m_uf[i]      = 1'b0;
            prev_gray[i] = '0;
        end
    endtask

    // Compare registered outputs of both instances with the model.
    task automatic check_state();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("empty[%0d]", i), 32'(empty_w[i]), 32'(m_empty[i]));
            check($sformatf("almost_empty[%0d]", i), 32'(ae_w[i]), 32'(m_ae[i]));
            check($sformatf("underflow[%0d]", i), 32'(uf_w[i]), 32'(m_uf[i]));
            check($sformatf("level[%0d]", i), 32'(level_w[i]), 32'(m_level[i]));
            check($sformatf("rd_addr[%0d]", i), 32'(addr_w[i]), 32'(m_rd[i] % DEPTH));
            check($sformatf("rd_ptr_gray[%0d]", i), 32'(gray_w[i]), 32'(gray_of(m_rd[i])));
            check($sformatf("gray_bits_changed[%0d]", i),
                  32'($countones(gray_w[i] ^ prev_gray[i])),
                  (m_rd[i] != m_rd_prev[i]) ? 32'd1 : 32'd0);
            prev_gray[i] = gray_w[i];
            m_rd_prev[i] = m_rd[i];
        end
    endtask

    // One read clock: check state, drive inputs, check rd_en, advance the model.
    task automatic step(input bit rd_req, input int wr_delta);
        int  seen;
        int  lvl;
        bit  en;
        @(negedge clk);
        check_state();
        inc     = rd_req;
        wr_cnt  = wr_cnt + wr_delta;
        wr_gray = gray_of(wr_cnt);
        #1;
        hist.push_back(wr_cnt);
        for (int i = 0; i < 2; i++) begin
            en = rd_req && !m_empty[i];
            check($sformatf("rd_en[%0d]", i), 32'(en_w[i]), 32'(en));
            seen       = (hist.size() > sync_of(i)) ? hist[hist.size() - 1 - sync_of(i)] : 0;
            m_rd[i]    = m_rd[i] + (en ? 1 : 0);
            lvl        = seen - m_rd[i];
            m_uf[i]    = rd_req && m_empty[i];
            m_empty[i] = (lvl == 0);
            m_ae[i]    = (lvl <= AE);
            m_level[i] = lvl;
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int min_rd;
        bit do_rd;
        bit do_wr;

        // Reset with write pointer 0.
        rst_n = 1'b0;
        model_reset();
        release_reset();
        step(0, 0);
        check("rst_empty", 32'(empty_w[0]), 32'd1);
        check("rst_level", 32'(level_w[0]), 32'd0);

        // Write pointer jumps to 3; two-stage instance shows it on the third edge.
        step(0, 3);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("sync_level3", 32'(level_w[0]), 32'd3);
        check("sync_not_empty", 32'(empty_w[0]), 32'd0);
        repeat (3) step(1, 0);
        step(0, 0);
        check("drain_empty", 32'(empty_w[0]), 32'd1);
        check("drain_addr", 32'(addr_w[0]), 32'd3);
        check("drain_level", 32'(level_w[0]), 32'd0);

        // Underflow: one blocked read, one-cycle pulse.
        step(1, 0);
        step(0, 0);
        check("underflow_pulse", 32'(uf_w[0]), 32'd1);
        check("underflow_ptr_held", 32'(addr_w[0]), 32'd3);
        step(0, 0);
        check("underflow_cleared", 32'(uf_w[0]), 32'd0);

        // Almost-empty threshold: level 5 then 2 after three reads.
        step(0, 5);
        repeat (3) step(0, 0);
        check("ae_level5", 32'(level_w[0]), 32'd5);
        check("ae_off", 32'(ae_w[0]), 32'd0);
        repeat (3) step(1, 0);
        step(0, 0);
        check("ae_level2", 32'(level_w[0]), 32'd2);
        check("ae_on", 32'(ae_w[0]), 32'd1);

        // Wrap: 40 write/read pairs carry the read pointers past 31 -> 0.
        repeat (40) step(1, 1);
        repeat (4) step(0, 0);

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("async_empty[%0d]", i), 32'(empty_w[i]), 32'd1);
            check($sformatf("async_ae[%0d]", i), 32'(ae_w[i]), 32'd1);
            check($sformatf("async_level[%0d]", i), 32'(level_w[i]), 32'd0);
            check($sformatf("async_gray[%0d]", i), 32'(gray_w[i]), 32'd0);
            check($sformatf("async_addr[%0d]", i), 32'(addr_w[i]), 32'd0);
            check($sformatf("async_uf[%0d]", i), 32'(uf_w[i]), 32'd0);
        end
        model_reset();
        inc = 1'b1;
        #1;
        check("async_rd_en_blocked", 32'(en_w[0]), 32'd0);
        inc = 1'b0;
        release_reset();

        // Bypassed instance reacts one edge after a write; synchronised one does not yet.
        step(0, 1);
        step(0, 0);
        check("bypass_not_empty", 32'(empty_w[1]), 32'd0);
        check("sync_still_empty", 32'(empty_w[0]), 32'd1);

        // Fill to depth, then read while the write pointer advances.
        repeat (DEPTH - 1) step(0, 1);
        repeat (3) step(0, 0);
        check("full_level_sync", 32'(level_w[0]), 32'(DEPTH));
        check("full_level_bypass", 32'(level_w[1]), 32'(DEPTH));
        step(1, 1);
        step(1, 1);
        step(0, 0);
        check("full_rw_bypass", 32'(level_w[1]), 32'(DEPTH));
        repeat (3) step(0, 0);
        check("full_rw_sync", 32'(level_w[0]), 32'(DEPTH));

        // Randomised traffic; writes never overfill the slower reader.
        for (int n = 0; n < 600; n++) begin
            min_rd = (m_rd[0] < m_rd[1]) ? m_rd[0] : m_rd[1];
            do_rd  = ($urandom_range(0, 99) < 55);
            do_wr  = ($urandom_range(0, 99) < 50) && ((wr_cnt - min_rd) < DEPTH);
            step(do_rd, do_wr ? 1 : 0);
        end
        @(negedge clk);
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
